edf_ar_arbiter: RTL
===================

EDF_AR_ARBITER -- requirements
Module: edf_ar_arbiter

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 40: AR address width on all ports.
REQ-002 SHALL have parameter C_S_AXI_ID_WIDTH, default 1: slave-side ID width. The master-side ID width SHALL be C_S_AXI_ID_WIDTH+1.
REQ-003 SHALL have parameter DEADLINE_WIDTH, default 16: width of the time counter and of each deadline register.
REQ-004 SHALL have parameters PERIOD_S00 = 64 and PERIOD_S01 = 16: relative deadline in cycles for each port.
REQ-005 SHALL have port aclk, input, 1 bit: single clock for the whole block.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have inputs s0X_axi_{arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0], arvalid} for X = 0, 1: read-address requests from each port.
REQ-008 SHALL have output s0X_axi_arready, 1 bit per port.
REQ-009 SHALL have outputs m00_axi_{arid, araddr, arlen, arsize, arburst, arvalid}: the granted request. m00_axi_arready SHALL be an input.
REQ-010 SHALL have inputs m00_axi_{rid, rdata[127:0], rresp, rlast, rvalid} and output m00_axi_rready.
REQ-011 SHALL have outputs s0X_axi_{rid, rdata, rresp, rlast, rvalid} and input s0X_axi_rready, per port.
REQ-012 SHALL have outputs miss_count_s00 and miss_count_s01, each 16 bits: deadline-miss counters.

Function
REQ-013 The time counter SHALL be DEADLINE_WIDTH bits, SHALL increment by 1 every cycle, and SHALL wrap modulo 2^DEADLINE_WIDTH.
REQ-014 Each port SHALL have a pending flag and a deadline register. On any cycle with arvalid=1 and pending=0: pending is set to 1 and deadline = time + PERIOD (mod 2^DEADLINE_WIDTH).
REQ-015 A port SHALL be eligible only when arvalid=1 and pending=1, giving a minimum 1-cycle arrival-to-eligible latency.
REQ-016 Deadline ordering SHALL use the signed DEADLINE_WIDTH difference d = dl00 - dl01. If d < 0, s00 is earlier; if d > 0, s01 is earlier; if d = 0, s00 wins the tie.
REQ-017 The FSM SHALL have two states, IDLE and ISSUE.
REQ-018 In IDLE with at least one eligible port, the block SHALL:
- grant the earliest-deadline port;
- assert that port's arready for exactly that cycle;
- latch arid/araddr/arlen/arsize/arburst into the output register;
- clear that port's pending flag;
- go to ISSUE.
REQ-019 In ISSUE, m00_axi_arvalid SHALL be 1 and all m00 AR fields SHALL be held stable. On m00_axi_arready=1 the FSM returns to IDLE. No s0X_axi_arready SHALL be asserted while in ISSUE.
REQ-020 m00_axi_arid SHALL equal {granted port index, latched arid}, with the port index as the MSB.
REQ-021 At grant, if signed(time - deadline) > 0 for the granted port, its miss counter SHALL increment by 1, saturating at 16'hFFFF.
REQ-022 The R channel SHALL be combinational:
- s0X_axi_rvalid = m00_axi_rvalid AND (m00_axi_rid MSB == X);
- m00_axi_rready = s0X_axi_rready of the port selected by the rid MSB;
- s0X rid/rdata/rresp/rlast = m00 values, with rid MSB stripped.
REQ-023 Minimum issue interval SHALL be 2 cycles (grant cycle, then at least 1 cycle in ISSUE).
REQ-024 A port whose arvalid drops before grant keeps its pending flag and deadline. This is unsupported by AXI and the behaviour is not otherwise specified.

Reset
REQ-025 With areset=1 at a rising edge of aclk, the following SHALL take effect on the next cycle:
- FSM = IDLE;
- time = 0;
- both pending flags = 0 and both deadlines = 0;
- miss counters = 0;
- output register cleared, m00_axi_arvalid = 0, s0X_axi_arready = 0.
REQ-026 Reset while in ISSUE SHALL drop the in-flight AR without completing it. The R-path outputs remain combinational functions of their inputs.

Verification
REQ-027 Reset: assert areset 2 cycles with arbitrary inputs -> m00_axi_arvalid=0, both arready=0, miss counters=0, time=0 after release.
REQ-028 Simultaneous arrival at time 0 (s00 addr 0x1000, s01 addr 0x2000, both arid=0) -> s01 granted first with m00_axi_arid=2'b10 and araddr=0x2000, then s00 with arid=2'b00 and araddr=0x1000.
REQ-029 Tie: PERIOD_S00=PERIOD_S01=32, simultaneous arrival -> s00 granted first.
REQ-030 Backpressure: m00_axi_arready held 0 for 5 cycles in ISSUE -> araddr/arlen/arid stable and arvalid=1 throughout, no s0X_axi_arready pulses; exactly 1 handshake when arready rises.
REQ-031 Wrap-around and miss:
- time preloaded near 0xFFF0, deadlines 0xFFF8 and 0x0010 (post-wrap) -> the 0xFFF8 port is granted first;
- arready held 0 for 40 cycles -> miss_count of the second-served port = 1.
REQ-032 R routing:
- m00_axi_rid=2'b10, rvalid=1 -> s01_axi_rvalid=1 with rid=0 and s00_axi_rvalid=0;
- m00_axi_rready follows s01_axi_rready.

Source files
------------

// File: rtl/edf_ar_arbiter.sv
// Two-port AXI read-address arbiter with earliest-deadline-first ordering.
// Each port's request is stamped with a deadline on arrival. The earliest deadline is
// granted and issued on m00. Read data is routed back using the MSB of rid.
module edf_ar_arbiter #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 40,
    parameter int unsigned C_S_AXI_ID_WIDTH = 1,
    parameter int unsigned DEADLINE_WIDTH   = 16,
    parameter int unsigned PERIOD_S00       = 64,
    parameter int unsigned PERIOD_S01       = 16
) (
    input  logic                          aclk,
    input  logic                          areset,

    // Port s00 AR channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [7:0]                    s00_axi_arlen,
    input  logic [2:0]                    s00_axi_arsize,
    input  logic [1:0]                    s00_axi_arburst,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,

    // Port s01 AR channel
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s01_axi_arid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s01_axi_araddr,
    input  logic [7:0]                    s01_axi_arlen,
    input  logic [2:0]                    s01_axi_arsize,
    input  logic [1:0]                    s01_axi_arburst,
    input  logic                          s01_axi_arvalid,
    output logic                          s01_axi_arready,

    // Master AR channel
    output logic [C_S_AXI_ID_WIDTH:0]     m00_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [7:0]                    m00_axi_arlen,
    output logic [2:0]                    m00_axi_arsize,
    output logic [1:0]                    m00_axi_arburst,
    output logic                          m00_axi_arvalid,
    input  logic                          m00_axi_arready,

    // Master R channel
    input  logic [C_S_AXI_ID_WIDTH:0]     m00_axi_rid,
    input  logic [127:0]                  m00_axi_rdata,
    input  logic [1:0]                    m00_axi_rresp,
    input  logic                          m00_axi_rlast,
    input  logic                          m00_axi_rvalid,
    output logic                          m00_axi_rready,

    // Port s00 R channel
    output logic [C_S_AXI_ID_WIDTH-1:0]   s00_axi_rid,
    output logic [127:0]                  s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rlast,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,

    // Port s01 R channel
    output logic [C_S_AXI_ID_WIDTH-1:0]   s01_axi_rid,
    output logic [127:0]                  s01_axi_rdata,
    output logic [1:0]                    s01_axi_rresp,
    output logic                          s01_axi_rlast,
    output logic                          s01_axi_rvalid,
    input  logic                          s01_axi_rready,

    // Deadline-miss counters
    output logic [15:0]                   miss_count_s00,
    output logic [15:0]                   miss_count_s01
);

    localparam int unsigned AW   = C_AXI_ADDR_WIDTH;
    localparam int unsigned IDW  = C_S_AXI_ID_WIDTH;
    localparam int unsigned MIDW = C_S_AXI_ID_WIDTH + 1;
    localparam int unsigned DW   = DEADLINE_WIDTH;
    localparam int unsigned CW   = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e              state_q,   state_d;
    logic [DW-1:0]       time_q,    time_d;
    logic                pend00_q,  pend00_d;
    logic                pend01_q,  pend01_d;
    logic [DW-1:0]       dl00_q,    dl00_d;
    logic [DW-1:0]       dl01_q,    dl01_d;
    logic [CW-1:0]       miss00_q,  miss00_d;
    logic [CW-1:0]       miss01_q,  miss01_d;
    logic [MIDW-1:0]     arid_q,    arid_d;
    logic [AW-1:0]       araddr_q,  araddr_d;
    logic [7:0]          arlen_q,   arlen_d;
    logic [2:0]          arsize_q,  arsize_d;
    logic [1:0]          arburst_q, arburst_d;
    logic                arvalid_q, arvalid_d;

    logic                elig00;
    logic                elig01;
    logic [DW-1:0]       dl_diff;
    logic                s01_earlier;
    logic                grant_any;
    logic                grant_sel;
    logic [DW-1:0]       lateness;
    logic                late;
    logic                r_sel;

    // Arbitration: eligibility, deadline compare (ties to s00), lateness of the winner
    always_comb begin
        elig00      = s00_axi_arvalid && pend00_q;
        elig01      = s01_axi_arvalid && pend01_q;
        dl_diff     = dl00_q - dl01_q;
        s01_earlier = !dl_diff[DW-1] && (dl_diff != '0);
        grant_any   = (state_q == IDLE) && (elig00 || elig01) && !areset;
        grant_sel   = (elig00 && elig01) ? s01_earlier : !elig00;
        lateness    = time_q - (grant_sel ? dl01_q : dl00_q);
        late        = !lateness[DW-1] && (lateness != '0);
    end

    // Ready pulses only in the grant cycle; never while a request is in flight
    always_comb begin
        s00_axi_arready = grant_any && !grant_sel;
        s01_axi_arready = grant_any &&  grant_sel;
    end

    // Next-state: time base, request stamping, grant latch and issue handshake
    always_comb begin
        state_d   = state_q;
        time_d    = time_q + DW'(1);
        pend00_d  = pend00_q;
        pend01_d  = pend01_q;
        dl00_d    = dl00_q;
        dl01_d    = dl01_q;
        miss00_d  = miss00_q;
        miss01_d  = miss01_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arvalid_d = arvalid_q;

        if (s00_axi_arvalid && !pend00_q) begin
            pend00_d = 1'b1;
            dl00_d   = time_q + DW'(PERIOD_S00);
        end
        if (s01_axi_arvalid && !pend01_q) begin
            pend01_d = 1'b1;
            dl01_d   = time_q + DW'(PERIOD_S01);
        end

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d   = ISSUE;
                    arvalid_d = 1'b1;
                    if (grant_sel) begin
                        arid_d    = {1'b1, s01_axi_arid};
                        araddr_d  = s01_axi_araddr;
                        arlen_d   = s01_axi_arlen;
                        arsize_d  = s01_axi_arsize;
                        arburst_d = s01_axi_arburst;
                        pend01_d  = 1'b0;
                        if (late && (miss01_q != 16'hFFFF)) begin
                            miss01_d = miss01_q + CW'(1);
                        end
                    end else begin
                        arid_d    = {1'b0, s00_axi_arid};
                        araddr_d  = s00_axi_araddr;
                        arlen_d   = s00_axi_arlen;
                        arsize_d  = s00_axi_arsize;
                        arburst_d = s00_axi_arburst;
                        pend00_d  = 1'b0;
                        if (late && (miss00_q != 16'hFFFF)) begin
                            miss00_d = miss00_q + CW'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                if (m00_axi_arready) begin
                    state_d   = IDLE;
                    arvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; an in-flight request is dropped
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            pend00_q  <= 1'b0;
            pend01_q  <= 1'b0;
            dl00_q    <= '0;
            dl01_q    <= '0;
            miss00_q  <= '0;
            miss01_q  <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pend00_q  <= pend00_d;
            pend01_q  <= pend01_d;
            dl00_q    <= dl00_d;
            dl01_q    <= dl01_d;
            miss00_q  <= miss00_d;
            miss01_q  <= miss01_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            arvalid_q <= arvalid_d;
        end
    end

    // Registered AR outputs and miss counters
    always_comb begin
        m00_axi_arid    = arid_q;
        m00_axi_araddr  = araddr_q;
        m00_axi_arlen   = arlen_q;
        m00_axi_arsize  = arsize_q;
        m00_axi_arburst = arburst_q;
        m00_axi_arvalid = arvalid_q;
        miss_count_s00  = miss00_q;
        miss_count_s01  = miss01_q;
    end

    // R channel: route by rid MSB, strip it on the way back to the port
    always_comb begin
        r_sel          = m00_axi_rid[MIDW-1];
        s00_axi_rid    = m00_axi_rid[IDW-1:0];
        s00_axi_rdata  = m00_axi_rdata;
        s00_axi_rresp  = m00_axi_rresp;
        s00_axi_rlast  = m00_axi_rlast;
        s00_axi_rvalid = m00_axi_rvalid && !r_sel;
        s01_axi_rid    = m00_axi_rid[IDW-1:0];
        s01_axi_rdata  = m00_axi_rdata;
        s01_axi_rresp  = m00_axi_rresp;
        s01_axi_rlast  = m00_axi_rlast;
        s01_axi_rvalid = m00_axi_rvalid && r_sel;
        m00_axi_rready = r_sel ? s01_axi_rready : s00_axi_rready;
    end

endmodule
